// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D memory port arbiter.
package mem_arbiter_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational grant select between the I and D miss ports.
// MEM_ARB_ROUND_ROBIN_EN: break ties against the side granted last; otherwise D wins ties.
module mem_arbiter_pick (
  input  logic i_valid,
  input  logic d_valid,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic rr_last_d,
`endif
  output logic grant_d
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On a tie, D only wins if I was the side served last.
  assign grant_d = d_valid & (~i_valid | ~rr_last_d);
`else
  assign grant_d = d_valid;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Merges the I-side and D-side miss ports onto one external memory port, one
// transaction in flight. MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BW_ADDRESS = 32,
  parameter int BW_BLOCK   = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  I_valid,
  input  logic                  I_r0w1,
  input  logic [BW_ADDRESS-1:0] I_rwaddr,
  input  logic [BW_BLOCK-1:0]   I_wdata,
  output logic                  I_ready,
  output logic [BW_BLOCK-1:0]   I_rdata,
  input  logic                  D_valid,
  input  logic                  D_r0w1,
  input  logic [BW_ADDRESS-1:0] D_rwaddr,
  input  logic [BW_BLOCK-1:0]   D_wdata,
  output logic                  D_ready,
  output logic [BW_BLOCK-1:0]   D_rdata,
  output logic                  mem_valid,
  output logic                  mem_r0w1,
  output logic [BW_ADDRESS-1:0] mem_rwaddr,
  output logic [BW_BLOCK-1:0]   mem_wdata,
  input  logic                  mem_ready,
  input  logic [BW_BLOCK-1:0]   mem_rdata
);

  typedef struct packed {
    logic                  r0w1;
    logic [BW_ADDRESS-1:0] rwaddr;
    logic [BW_BLOCK-1:0]   wdata;
  } req_t;

  state_t              state;
  owner_t              owner;
  req_t                req_q;
  req_t                i_req;
  req_t                d_req;
  logic [BW_BLOCK-1:0] rsp_q;
  logic                grant_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_t rr_last;
`endif

  assign i_req = '{r0w1: I_r0w1, rwaddr: I_rwaddr, wdata: I_wdata};
  assign d_req = '{r0w1: D_r0w1, rwaddr: D_rwaddr, wdata: D_wdata};

  mem_arbiter_pick u_pick (
    .i_valid   (I_valid),
    .d_valid   (D_valid),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .rr_last_d (rr_last == OWN_D),
`endif
    .grant_d   (grant_d)
  );

  // Memory-side fields come straight from the request register, so they are
  // stable for the whole busy window.
  assign mem_r0w1   = req_q.r0w1;
  assign mem_rwaddr = req_q.rwaddr;
  assign mem_wdata  = req_q.wdata;

  // Single response register; the ready pulse alone identifies the owner.
  assign I_rdata = rsp_q;
  assign D_rdata = rsp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      owner     <= OWN_I;
      req_q     <= '0;
      rsp_q     <= '0;
      mem_valid <= 1'b0;
      I_ready   <= 1'b0;
      D_ready   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_last   <= OWN_I;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (I_valid || D_valid) begin
            state     <= S_BUSY;
            mem_valid <= 1'b1;
            owner     <= grant_d ? OWN_D : OWN_I;
            req_q     <= grant_d ? d_req : i_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_last   <= grant_d ? OWN_D : OWN_I;
`endif
          end
        end
        S_BUSY: begin
          if (mem_ready) begin
            state     <= S_RESP;
            mem_valid <= 1'b0;
            rsp_q     <= mem_rdata;
            I_ready   <= (owner == OWN_I);
            D_ready   <= (owner == OWN_D);
          end
        end
        S_RESP: begin
          // Requester updates valid during the following idle cycle, so a
          // stale valid is never seen by S_IDLE.
          state   <= S_IDLE;
          I_ready <= 1'b0;
          D_ready <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          mem_valid <= 1'b0;
          I_ready   <= 1'b0;
          D_ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: side drivers, memory responder and a
// response monitor share an in-order expectation queue.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int BW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          I_valid, I_r0w1, I_ready;
  logic [AW-1:0] I_rwaddr;
  logic [BW-1:0] I_wdata, I_rdata;
  logic          D_valid, D_r0w1, D_ready;
  logic [AW-1:0] D_rwaddr;
  logic [BW-1:0] D_wdata, D_rdata;
  logic          mem_valid, mem_r0w1, mem_ready;
  logic [AW-1:0] mem_rwaddr;
  logic [BW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.BW_ADDRESS(AW), .BW_BLOCK(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .I_valid(I_valid), .I_r0w1(I_r0w1), .I_rwaddr(I_rwaddr), .I_wdata(I_wdata),
    .I_ready(I_ready), .I_rdata(I_rdata),
    .D_valid(D_valid), .D_r0w1(D_r0w1), .D_rwaddr(D_rwaddr), .D_wdata(D_wdata),
    .D_ready(D_ready), .D_rdata(D_rdata),
    .mem_valid(mem_valid), .mem_r0w1(mem_r0w1), .mem_rwaddr(mem_rwaddr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic          r0w1;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
  } req_t;

  typedef struct {
    logic          is_d;
    logic          r0w1;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
    int            lat;
    logic [BW-1:0] fill;
    logic          chk_rd;
    logic [BW-1:0] rdata;
    int            exp_lat;
  } exp_t;

  typedef struct {
    logic          is_d;
    logic          r0w1;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
    int            lat;
    logic [BW-1:0] fill;
    logic [BW-1:0] exp_rdata;
  } vec_t;

  req_t i_q[$];
  req_t d_q[$];
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   i_start = 0;
  int   d_start = 0;
  bit   i_done, d_done;
  bit   flush = 1'b0;
  bit   stray = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_req(input logic is_d, input logic r0w1, input logic [AW-1:0] addr,
                          input logic [BW-1:0] wdata);
    req_t r;
    r = '{r0w1, addr, wdata};
    if (is_d) d_q.push_back(r);
    else      i_q.push_back(r);
  endtask

  task automatic push_exp(input logic is_d, input logic r0w1, input logic [AW-1:0] addr,
                          input logic [BW-1:0] wdata, input int lat, input logic [BW-1:0] fill,
                          input logic [BW-1:0] rdata, input int exp_lat);
    exp_t e;
    e = '{is_d, r0w1, addr, wdata, lat, fill, !r0w1, rdata, exp_lat};
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || i_q.size() != 0 || d_q.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size() == 0 && i_q.size() == 0 && d_q.size() == 0, 1'b1);
    exp_q.delete();
    i_q.delete();
    d_q.delete();
    repeat (2) @(negedge clk);
  endtask

  // Requesters: load the next request when idle or in the cycle after ready.
  initial begin
    req_t r;
    I_valid = 0; I_r0w1 = 0; I_rwaddr = '0; I_wdata = '0; i_done = 0;
    forever begin
      @(posedge clk); #1;
      if (flush) begin
        I_valid = 0; i_done = 0;
      end else if (i_done || !I_valid) begin
        i_done = 0;
        if (i_q.size() != 0) begin
          r = i_q.pop_front();
          I_valid = 1; I_r0w1 = r.r0w1; I_rwaddr = r.addr; I_wdata = r.wdata;
          i_start = cyc;
        end else I_valid = 0;
      end else if (I_ready) i_done = 1;
    end
  end

  initial begin
    req_t r;
    D_valid = 0; D_r0w1 = 0; D_rwaddr = '0; D_wdata = '0; d_done = 0;
    forever begin
      @(posedge clk); #1;
      if (flush) begin
        D_valid = 0; d_done = 0;
      end else if (d_done || !D_valid) begin
        d_done = 0;
        if (d_q.size() != 0) begin
          r = d_q.pop_front();
          D_valid = 1; D_r0w1 = r.r0w1; D_rwaddr = r.addr; D_wdata = r.wdata;
          d_start = cyc;
        end else D_valid = 0;
      end else if (D_ready) d_done = 1;
    end
  end

  // Memory model: checks request fields against the head expectation and
  // answers after that entry's latency with fill ^ {4{addr}}.
  initial begin
    bit            m_busy;
    int            m_cnt, m_lat, m_last_rdy;
    req_t          m_cur;
    logic [BW-1:0] m_fill;
    mem_ready = 0; mem_rdata = '0;
    m_busy = 0; m_cnt = 0; m_lat = 0; m_last_rdy = -100; m_fill = '0;
    m_cur = '{1'b0, '0, '0};
    forever begin
      @(posedge clk); #1;
      mem_ready = 0;
      if (!rst_n) begin
        m_busy = 0; m_last_rdy = -100;
      end else if (mem_valid) begin
        if (!m_busy) begin
          m_busy = 1; m_cnt = 0;
          m_cur = '{mem_r0w1, mem_rwaddr, mem_wdata};
          check("mem_idle_gap", (cyc - m_last_rdy) >= 3, 1'b1);
          check("expected_mem_req", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            check("mem_r0w1", mem_r0w1, exp_q[0].r0w1);
            check("mem_rwaddr", mem_rwaddr, exp_q[0].addr);
            check("mem_wdata", mem_wdata, exp_q[0].wdata);
            m_lat = exp_q[0].lat; m_fill = exp_q[0].fill;
          end else begin
            m_lat = 0; m_fill = '0;
          end
        end else begin
          check("mem_hold", mem_r0w1 === m_cur.r0w1 && mem_rwaddr === m_cur.addr &&
                mem_wdata === m_cur.wdata, 1'b1);
        end
        if (m_cnt == m_lat) begin
          mem_ready = 1; mem_rdata = m_fill ^ {4{m_cur.addr}};
          m_busy = 0; m_last_rdy = cyc;
        end
        m_cnt++;
      end else if (m_busy) begin
        check("mem_valid_held", mem_valid, 1'b1);
        m_busy = 0;
      end else if (stray) begin
        mem_ready = 1; mem_rdata = {4{32'hBAD0_0BAD}};
        stray = 0;
      end
    end
  end

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (I_ready || D_ready) begin
        if (exp_q.size() == 0) check("spurious_ready", {I_ready, D_ready}, 2'b00);
        else begin
          e = exp_q.pop_front();
          check("ready_owner", {D_ready, I_ready}, e.is_d ? 2'b10 : 2'b01);
          check("resp_mem_valid_low", mem_valid, 1'b0);
          if (e.chk_rd) check("rdata", e.is_d ? D_rdata : I_rdata, e.rdata);
          if (e.exp_lat >= 0) check("latency", cyc - (e.is_d ? d_start : i_start), e.exp_lat);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   n;
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0040, {4{32'h1111_2222}}, 3, {4{32'hA5A5_A5E5}}, {4{32'hA5A5_A5A5}}};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0080, 128'h1234, 2, '0, '0};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_1000, '0, 0, '0, {4{32'h0000_1000}}};
    vecs[3] = '{1'b1, 1'b1, 32'hFFFF_FFF0, {BW{1'b1}}, 5, '0, '0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0044, {4{32'h5555_AAAA}}, 1, {4{32'hDEAD_BEEF}}, {4{32'hDEAD_BEAB}}};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_00C0, '0, 4, '0, {4{32'h0000_00C0}}};

    rst_n = 0;
    repeat (2) @(negedge clk);
    check("rst_mem_valid", mem_valid, 1'b0);
    check("rst_I_ready", I_ready, 1'b0);
    check("rst_D_ready", D_ready, 1'b0);
    check("rst_mem_r0w1", mem_r0w1, 1'b0);
    check("rst_mem_rwaddr", mem_rwaddr, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_rdata", I_rdata, '0);
    rst_n = 1;
    @(negedge clk);

    // Simultaneous request straight after reset: D first, then I.
    push_req(1'b0, 1'b0, 32'h100, 128'h0);
    push_req(1'b1, 1'b0, 32'h200, 128'h0);
    push_exp(1'b1, 1'b0, 32'h200, 128'h0, 2, '0, {4{32'h200}}, 4);
    push_exp(1'b0, 1'b0, 32'h100, 128'h0, 1, '0, {4{32'h100}}, -1);
    wait_drain(100);

    // Single-requester vectors (last one is I so a following tie goes to D).
    for (int v = 0; v < 6; v++) begin
      push_req(vecs[v].is_d, vecs[v].r0w1, vecs[v].addr, vecs[v].wdata);
      push_exp(vecs[v].is_d, vecs[v].r0w1, vecs[v].addr, vecs[v].wdata, vecs[v].lat,
               vecs[v].fill, vecs[v].exp_rdata, vecs[v].lat + 2);
      wait_drain(100);
    end

    // Three back-to-back tie pairs.
    for (int k = 0; k < 3; k++) begin
      push_req(1'b0, 1'b0, 32'h400 + 32'(k * 4), '0);
      push_req(1'b1, 1'b0, 32'h500 + 32'(k * 4), '0);
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 3; k++) begin
      push_exp(1'b1, 1'b0, 32'h500 + 32'(k * 4), '0, 1, '0, {4{32'h500 + 32'(k * 4)}}, -1);
      push_exp(1'b0, 1'b0, 32'h400 + 32'(k * 4), '0, 1, '0, {4{32'h400 + 32'(k * 4)}}, -1);
    end
`else
    for (int k = 0; k < 3; k++)
      push_exp(1'b1, 1'b0, 32'h500 + 32'(k * 4), '0, 1, '0, {4{32'h500 + 32'(k * 4)}}, -1);
    for (int k = 0; k < 3; k++)
      push_exp(1'b0, 1'b0, 32'h400 + 32'(k * 4), '0, 1, '0, {4{32'h400 + 32'(k * 4)}}, -1);
`endif
    wait_drain(200);

    // Stray mem_ready while idle must be ignored.
    stray = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stray_no_ready", {I_ready, D_ready}, 2'b00);
      check("stray_no_mem_valid", mem_valid, 1'b0);
    end
    push_req(1'b0, 1'b0, 32'h600, '0);
    push_exp(1'b0, 1'b0, 32'h600, '0, 0, '0, {4{32'h600}}, 2);
    wait_drain(100);

    // Reset while busy, then a fresh D request.
    push_req(1'b1, 1'b0, 32'h700, '0);
    push_exp(1'b1, 1'b0, 32'h700, '0, 20, '0, {4{32'h700}}, 22);
    n = 0;
    while (!mem_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("busy_before_reset", mem_valid, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 0;
    flush = 1;
    #1;
    check("rst_busy_mem_valid", mem_valid, 1'b0);
    check("rst_busy_I_ready", I_ready, 1'b0);
    check("rst_busy_D_ready", D_ready, 1'b0);
    exp_q.delete();
    i_q.delete();
    d_q.delete();
    repeat (3) @(negedge clk);
    flush = 0;
    rst_n = 1;
    repeat (2) @(negedge clk);
    push_req(1'b1, 1'b0, 32'h300, '0);
    push_exp(1'b1, 1'b0, 32'h300, '0, 2, '0, {4{32'h300}}, 4);
    wait_drain(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
